// File: rtl/stream_demux_1xn_if.sv
// Handshake bundle for stream_demux_1xn: one input stream and N output channels.
// The master side is the producer plus the channel consumers; the slave side is the demux.
interface stream_demux_1xn_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 8,
  parameter int unsigned SEL_W = 4
);
  logic [WIDTH-1:0]   in_data;
  logic [SEL_W-1:0]   in_sel;
  logic               in_bcast;
  logic               in_valid;
  logic               in_ready;
  logic [N*WIDTH-1:0] out_data;
  logic [N-1:0]       out_valid;
  logic [N-1:0]       out_ready;

  modport master (
    output in_data, in_sel, in_bcast, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_sel, in_bcast, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/stream_demux_1xn.sv
// Registered 1-to-N stream demux: unicast by select or broadcast, one-entry register per
// channel, and a saturating count of words dropped for an out-of-range select.
module stream_demux_1xn #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 8,
  parameter int unsigned SEL_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  stream_demux_1xn_if.slave    bus,
  output logic [CNT_W-1:0]     drop_cnt
);

  logic [N-1:0]       r_valid;
  logic [N*WIDTH-1:0] r_data;
  logic [CNT_W-1:0]   r_drop_cnt;

  logic [N-1:0] w_free;
  logic [N-1:0] w_load;
  logic         w_sel_ok;
  logic         w_sel_free;
  logic         w_in_ready;
  logic         w_acc;
  logic         w_drop;

  always_comb begin
    w_sel_ok   = 32'(bus.in_sel) < N;
    w_sel_free = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      // A channel can load in the same cycle its current word drains.
      w_free[i] = !r_valid[i] || bus.out_ready[i];
      if (bus.in_sel == SEL_W'(i)) begin
        w_sel_free = w_free[i];
      end
    end

    if (bus.in_bcast) begin
      w_in_ready = &w_free;
    end else if (w_sel_ok) begin
      w_in_ready = w_sel_free;
    end else begin
      w_in_ready = 1'b1;
    end

    w_acc  = bus.in_valid && w_in_ready;
    w_drop = w_acc && !bus.in_bcast && !w_sel_ok;
    for (int i = 0; i < int'(N); i++) begin
      w_load[i] = w_acc && (bus.in_bcast || (bus.in_sel == SEL_W'(i)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= '0;
      r_data     <= '0;
      r_drop_cnt <= '0;
    end else begin
      for (int i = 0; i < int'(N); i++) begin
        // Load wins over drain; data is left in place when a channel empties.
        if (w_load[i]) begin
          r_valid[i]                <= 1'b1;
          r_data[i*WIDTH +: WIDTH]  <= bus.in_data;
        end else if (bus.out_ready[i]) begin
          r_valid[i] <= 1'b0;
        end
      end
      if (w_drop && (r_drop_cnt != {CNT_W{1'b1}})) begin
        r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_valid;
  assign bus.out_data  = r_data;
  assign drop_cnt      = r_drop_cnt;

endmodule

// File: tb/tb_stream_demux_1xn.sv
// Bench for stream_demux_1xn: directed scenarios plus random traffic against a queue-based
// model of the channels, and a small-parameter instance for out-of-range and saturation.
module tb_stream_demux_1xn;

  localparam int N  = 8;
  localparam int NS = 6;

  logic clk;
  logic rst;
  logic [15:0] drop_cnt;
  logic [1:0]  drop_cnt_s;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  stream_demux_1xn_if #(.WIDTH(8), .N(N), .SEL_W(4)) u_if ();
  stream_demux_1xn_if #(.WIDTH(8), .N(NS), .SEL_W(3)) u_sif ();

  stream_demux_1xn #(.WIDTH(8), .N(N), .SEL_W(4), .CNT_W(16)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (u_if),
    .drop_cnt (drop_cnt)
  );

  stream_demux_1xn #(.WIDTH(8), .N(NS), .SEL_W(3), .CNT_W(2)) u_dut_s (
    .clk      (clk),
    .rst      (rst),
    .bus      (u_sif),
    .drop_cnt (drop_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Channel model: each channel is a queue holding at most one word.
  logic [7:0]  m_q[N][$];
  logic [7:0]  m_last[N];
  int unsigned m_drop;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_free(int i);
    return (m_q[i].size() == 0) || u_if.out_ready[i];
  endfunction

  function automatic bit m_in_ready();
    if (u_if.in_bcast) begin
      for (int i = 0; i < N; i++) if (!m_free(i)) return 1'b0;
      return 1'b1;
    end
    if (int'(u_if.in_sel) < N) return m_free(int'(u_if.in_sel));
    return 1'b1;
  endfunction

  task automatic m_edge();
    bit acc;
    acc = u_if.in_valid && m_in_ready();
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_q[i].delete();
        m_last[i] = 8'h00;
      end
      m_drop = 0;
      return;
    end
    for (int i = 0; i < N; i++) begin
      if (m_q[i].size() > 0 && u_if.out_ready[i]) void'(m_q[i].pop_front());
    end
    if (acc) begin
      if (u_if.in_bcast) begin
        for (int i = 0; i < N; i++) begin
          m_q[i].push_back(u_if.in_data);
          m_last[i] = u_if.in_data;
        end
      end else if (int'(u_if.in_sel) < N) begin
        m_q[int'(u_if.in_sel)].push_back(u_if.in_data);
        m_last[int'(u_if.in_sel)] = u_if.in_data;
      end else if (m_drop < 65535) begin
        m_drop++;
      end
    end
  endtask

  // One clock: check in_ready against the model, step the model, then check the outputs.
  task automatic cyc(string tag);
    logic [7:0]  ev;
    logic [63:0] ed;
    #1;
    if (!rst) chk({tag, " in_ready"}, 64'(u_if.in_ready), 64'(m_in_ready()));
    m_edge();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      ev[i]          = m_q[i].size() > 0;
      ed[i*8 +: 8]   = m_last[i];
    end
    chk({tag, " out_valid"}, 64'(u_if.out_valid), 64'(ev));
    chk({tag, " out_data"}, u_if.out_data, ed);
    chk({tag, " drop_cnt"}, 64'(drop_cnt), 64'(m_drop));
  endtask

  task automatic drive(logic v, logic b, logic [3:0] s, logic [7:0] d, logic [7:0] r);
    u_if.in_valid  = v;
    u_if.in_bcast  = b;
    u_if.in_sel    = s;
    u_if.in_data   = d;
    u_if.out_ready = r;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 1'b0, 4'd0, 8'hFF, 8'hFF);
    u_sif.in_valid  = 1'b0;
    u_sif.in_bcast  = 1'b0;
    u_sif.in_sel    = 3'd0;
    u_sif.in_data   = 8'h00;
    u_sif.out_ready = '1;
    @(posedge clk);
    #1;

    // Reset held with in_valid high: nothing loads.
    cyc("reset0");
    cyc("reset1");
    chk("reset out_valid", 64'(u_if.out_valid), 64'h00);
    rst = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
    for (int s = 0; s < 16; s++) begin
      u_if.in_sel = 4'(s);
      #1;
      chk("post-reset in_ready", 64'(u_if.in_ready), 64'h1);
    end

    // Unicast sweep at full rate.
    for (int k = 0; k < N; k++) begin
      drive(1'b1, 1'b0, 4'(k), 8'hA0 + 8'(k), 8'hFF);
      cyc("sweep");
    end
    drive(1'b0, 1'b0, 4'd0, 8'h00, 8'hFF);
    chk("sweep ch7 data", 64'(u_if.out_data[7*8 +: 8]), 64'hA7);
    cyc("sweep drain");

    // Back-pressure on channel 3.
    drive(1'b1, 1'b0, 4'd3, 8'h11, 8'hF7);
    cyc("bp first");
    drive(1'b1, 1'b0, 4'd3, 8'h22, 8'hF7);
    cyc("bp stall0");
    cyc("bp stall1");
    chk("bp held data", 64'(u_if.out_data[3*8 +: 8]), 64'h11);
    u_if.out_ready = 8'hFF;
    cyc("bp release");
    chk("bp valid kept", 64'(u_if.out_valid[3]), 64'h1);
    chk("bp new data", 64'(u_if.out_data[3*8 +: 8]), 64'h22);
    drive(1'b0, 1'b0, 4'd0, 8'h00, 8'hFF);
    cyc("bp drain");

    // Broadcast blocked by a full, stalled channel 5.
    drive(1'b1, 1'b0, 4'd5, 8'h33, 8'hDF);
    cyc("bc fill5");
    drive(1'b1, 1'b1, 4'd0, 8'h5A, 8'hDF);
    #1;
    chk("bc blocked in_ready", 64'(u_if.in_ready), 64'h0);
    cyc("bc stall");
    u_if.out_ready = 8'hFF;
    cyc("bc accept");
    chk("bc out_valid", 64'(u_if.out_valid), 64'hFF);
    chk("bc out_data", u_if.out_data, 64'h5A5A_5A5A_5A5A_5A5A);
    drive(1'b0, 1'b0, 4'd0, 8'h00, 8'hFF);
    cyc("bc drain");

    // Out-of-range selects on the default instance.
    for (int s = 8; s < 16; s++) begin
      drive(1'b1, 1'b0, 4'(s), 8'(s), 8'h00);
      cyc("oor");
    end
    chk("oor drop_cnt", 64'(drop_cnt), 64'd8);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
            4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
      cyc("rnd");
    end

    // Reset mid-operation with channels 0 and 2 full and stalled.
    drive(1'b0, 1'b0, 4'd0, 8'h00, 8'hFF);
    cyc("mid flush");
    drive(1'b1, 1'b0, 4'd0, 8'hC0, 8'h00);
    cyc("mid fill0");
    drive(1'b1, 1'b0, 4'd2, 8'hC2, 8'h00);
    cyc("mid fill2");
    rst = 1'b1;
    cyc("mid reset");
    chk("mid reset out_valid", 64'(u_if.out_valid), 64'h00);
    chk("mid reset drop_cnt", 64'(drop_cnt), 64'h0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 8'h00, 8'hFF);
    cyc("mid after0");
    cyc("mid after1");
    chk("mid no reappear", 64'(u_if.out_valid), 64'h00);

    // Small instance: N=6, SEL_W=3, CNT_W=2.
    u_sif.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      u_sif.in_sel  = (k % 2 == 0) ? 3'd6 : 3'd7;
      u_sif.in_data = 8'(k);
      #1;
      chk("small oor in_ready", 64'(u_sif.in_ready), 64'h1);
      @(posedge clk);
      #1;
      chk("small oor out_valid", 64'(u_sif.out_valid), 64'h0);
      if (k == 1) chk("small drop two", 64'(drop_cnt_s), 64'd2);
    end
    chk("small drop saturate", 64'(drop_cnt_s), 64'd3);
    u_sif.in_sel  = 3'd2;
    u_sif.in_data = 8'h77;
    @(posedge clk);
    #1;
    u_sif.in_valid = 1'b0;
    chk("small load valid", 64'(u_sif.out_valid), 64'h04);
    chk("small load data", 64'(u_sif.out_data[2*8 +: 8]), 64'h77);
    chk("small drop held", 64'(drop_cnt_s), 64'd3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
